// File: rtl/tube_pkg.sv
// tube_pkg: shared constants and helpers for the Tube ULA FIFO channels
// Holds status bit positions, register indices, per-register default depths
// and the occupancy-count width function used by every channel instance.
package tube_pkg;
    localparam int AVAIL_BIT   = 7;
    localparam int NOTFULL_BIT = 6;

    localparam logic [1:0] R1 = 2'd0;
    localparam logic [1:0] R2 = 2'd1;
    localparam logic [1:0] R3 = 2'd2;
    localparam logic [1:0] R4 = 2'd3;

    localparam int R1_P2H_DEPTH = 24;
    localparam int R1_H2P_DEPTH = 1;
    localparam int R2_DEPTH     = 1;
    localparam int R3_DEPTH     = 2;
    localparam int R4_DEPTH     = 1;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/tube_fifo_channel_if.sv
// tube_fifo_channel_if: handshake/status bundle between a Tube register user and its FIFO
// master: drives FLUSH, MULTI, WR_EN, WR_DATA, RD_EN, IRQ_EN; observes RD_DATA, AVAIL,
//         NOTFULL, IRQ, COUNT (and OVERRUN/UNDERRUN when TUBE_FIFO_ERR_FLAGS_EN is defined)
// slave:  the FIFO channel itself, opposite directions
interface tube_fifo_channel_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 24
);
    import tube_pkg::*;
    logic                      FLUSH;
    logic                      MULTI;
    logic                      WR_EN;
    logic [WIDTH-1:0]          WR_DATA;
    logic                      RD_EN;
    logic [WIDTH-1:0]          RD_DATA;
    logic                      AVAIL;
    logic                      NOTFULL;
    logic                      IRQ_EN;
    logic                      IRQ;
    logic [count_w(DEPTH)-1:0] COUNT;
`ifdef TUBE_FIFO_ERR_FLAGS_EN
    logic                      OVERRUN;
    logic                      UNDERRUN;
    modport master (
        output FLUSH, MULTI, WR_EN, WR_DATA, RD_EN, IRQ_EN,
        input  RD_DATA, AVAIL, NOTFULL, IRQ, COUNT, OVERRUN, UNDERRUN
    );
    modport slave (
        input  FLUSH, MULTI, WR_EN, WR_DATA, RD_EN, IRQ_EN,
        output RD_DATA, AVAIL, NOTFULL, IRQ, COUNT, OVERRUN, UNDERRUN
    );
`else
    modport master (
        output FLUSH, MULTI, WR_EN, WR_DATA, RD_EN, IRQ_EN,
        input  RD_DATA, AVAIL, NOTFULL, IRQ, COUNT
    );
    modport slave (
        input  FLUSH, MULTI, WR_EN, WR_DATA, RD_EN, IRQ_EN,
        output RD_DATA, AVAIL, NOTFULL, IRQ, COUNT
    );
`endif
endinterface

// File: rtl/tube_fifo_ram.sv
// tube_fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read
// Ports: clk, we, waddr, wdata (write side); raddr -> rdata (combinational read).
// Contents are deliberately not reset.
module tube_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 24,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/tube_fifo_channel.sv
// tube_fifo_channel: parametrised byte FIFO for one direction of a Tube ULA register
// Ports: HO2 (clock), HRST (async active-low reset), bus (tube_fifo_channel_if.slave):
//   FLUSH, MULTI, WR_EN/WR_DATA, RD_EN/RD_DATA (show-ahead), AVAIL, NOTFULL,
//   IRQ_EN/IRQ, COUNT. Defining TUBE_FIFO_ERR_FLAGS_EN adds sticky OVERRUN/UNDERRUN.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module tube_fifo_channel
    import tube_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 24,
    parameter int MULTI_N = 2
) (
    input logic                 HO2,
    input logic                 HRST,
    tube_fifo_channel_if.slave  bus
);
    localparam int CW = count_w(DEPTH);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] ram_q;
    logic             push, pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign pop  = bus.RD_EN & ~bus.FLUSH & (count != '0);
    assign push = bus.WR_EN & ~bus.FLUSH & ((count < CW'(DEPTH)) | pop);

    always_ff @(posedge HO2 or negedge HRST)
        if (!HRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.FLUSH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= bump(tail);
            if (pop) head <= bump(head);
            count <= count + CW'(push) - CW'(pop);
        end

    tube_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk  (HO2),
        .we   (push),
        .waddr(tail),
        .wdata(bus.WR_DATA),
        .raddr(head),
        .rdata(ram_q)
    );

    // Status is purely a function of the registered count, so it is glitch-free
    // and follows MULTI changes in the same cycle without touching contents.
    assign bus.RD_DATA = (count != '0) ? ram_q : '0;
    assign bus.AVAIL   = bus.MULTI ? (count >= CW'(MULTI_N)) : (count != '0);
    assign bus.NOTFULL = bus.MULTI ? (count == '0) : (count < CW'(DEPTH));
    assign bus.IRQ     = bus.IRQ_EN & bus.AVAIL;
    assign bus.COUNT   = count;

`ifdef TUBE_FIFO_ERR_FLAGS_EN
    logic overrun, underrun;

    always_ff @(posedge HO2 or negedge HRST)
        if (!HRST) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (bus.FLUSH) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (bus.WR_EN & ~push) overrun <= 1'b1;
            if (bus.RD_EN & (count == '0)) underrun <= 1'b1;
        end

    assign bus.OVERRUN  = overrun;
    assign bus.UNDERRUN = underrun;
`else
`endif
endmodule
